// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared constants, FSM state type and width helper for stream_mux
package stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  // Channel-id width; never narrower than one bit.
  function automatic int chw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_arbiter.sv
// rtl/stream_mux_arbiter.sv - combinational fixed-priority / round-robin grant picker
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int MODE = MODE_FIXED,
  parameter int CHW  = chw_of(NCH)
) (
  input  logic [NCH-1:0] req_i,
  input  logic [CHW-1:0] ptr_i,
  output logic [NCH-1:0] grant_o,
  output logic [CHW-1:0] index_o
);

  int   idx;
  logic found;

  // Scan channels starting at the pointer (round-robin) or at zero (fixed); first requester wins.
  always_comb begin
    grant_o = '0;
    index_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NCH; k++) begin
      idx = (MODE == MODE_RR) ? ((int'(ptr_i) + k) % NCH) : k;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        index_o      = CHW'(idx);
      end
    end
  end

endmodule

// File: rtl/stream_mux.sv
// rtl/stream_mux.sv - N-channel packet-locked stream selector with registered output stage
module stream_mux
  import stream_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = MODE_FIXED,
  localparam int CHW  = chw_of(NCH)
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [NCH-1:0]       in_valid_i,
  output logic [NCH-1:0]       in_ready_o,
  input  logic [NCH*WIDTH-1:0] in_data_i,
  input  logic [NCH-1:0]       in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_last_o,
  output logic [CHW-1:0]       out_ch_o
);

  state_e             state_q;
  logic [CHW-1:0]     lock_q;
  logic [CHW-1:0]     ptr_q;
  logic [CHW-1:0]     ptr_d;
  logic               out_valid_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_last_q;
  logic [CHW-1:0]     out_ch_q;

  logic               load;
  logic [NCH-1:0]     arb_grant;
  logic [CHW-1:0]     arb_index;
  logic [NCH-1:0]     gnt;
  logic [CHW-1:0]     sel;
  logic               accept;
  logic               sel_last;
  logic [WIDTH-1:0]   sel_data;

  // The output register can take a new beat when empty or when its beat leaves this cycle.
  assign load = !out_valid_q | out_ready_i;

  rr_arbiter #(
    .NCH  (NCH),
    .MODE (MODE),
    .CHW  (CHW)
  ) u_arb (
    .req_i   (in_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .index_o (arb_index)
  );

  // While locked only the owning channel may be granted; otherwise the arbiter decides.
  always_comb begin
    gnt = '0;
    sel = arb_index;
    if (state_q == ST_LOCK) begin
      sel         = lock_q;
      gnt[lock_q] = in_valid_i[lock_q];
    end else begin
      gnt = arb_grant;
    end
  end

  assign in_ready_o = load ? gnt : '0;
  assign accept     = |(in_valid_i & in_ready_o);
  assign sel_last   = in_last_i[sel];
  assign sel_data   = in_data_i[int'(sel)*WIDTH +: WIDTH];
  assign ptr_d      = (sel == CHW'(NCH - 1)) ? '0 : sel + CHW'(1);

  // Packet-lock FSM plus round-robin pointer, which advances past the winner at end of packet.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (!sel_last) begin
            state_q <= ST_LOCK;
            lock_q  <= sel;
          end
        end
        ST_LOCK: begin
          if (sel_last) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
      if (sel_last && (MODE == MODE_RR)) begin
        ptr_q <= ptr_d;
      end
    end
  end

  // Output stage: load on acceptance, empty when drained with nothing new, hold under backpressure.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else if (load) begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_ch_q    <= sel;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_ch_o    = out_ch_q;

endmodule

// File: tb/tb_stream_mux.sv
// tb/tb_stream_mux.sv - directed self-checking bench for stream_mux in fixed and round-robin modes
module tb_stream_mux;

  localparam int WIDTH = 32;
  localparam int NCH   = 4;
  localparam int CHW   = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       in_valid;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_last;
  logic                 out_ready;

  logic [NCH-1:0]   f_in_ready, r_in_ready;
  logic             f_out_valid, r_out_valid;
  logic [WIDTH-1:0] f_out_data, r_out_data;
  logic             f_out_last, r_out_last;
  logic [CHW-1:0]   f_out_ch, r_out_ch;

  int checks;
  int failures;

  stream_mux #(.WIDTH(WIDTH), .NCH(NCH), .MODE(0)) u_fix (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(f_in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(f_out_valid),
    .out_ready_i(out_ready), .out_data_o(f_out_data), .out_last_o(f_out_last),
    .out_ch_o(f_out_ch)
  );

  stream_mux #(.WIDTH(WIDTH), .NCH(NCH), .MODE(1)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(r_in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_valid_o(r_out_valid),
    .out_ready_i(out_ready), .out_data_o(r_out_data), .out_last_o(r_out_last),
    .out_ch_o(r_out_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] d, input logic l);
    in_data[k*WIDTH +: WIDTH] = d;
    in_last[k] = l;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 4'hF;
    in_data   = '0;
    in_last   = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < NCH; k++) set_ch(k, 32'hD0 + k, 1'b1);

    // Reset with every channel requesting
    step();
    step();
    chk("rst_f_valid", f_out_valid, 0);
    chk("rst_f_data",  f_out_data, 0);
    chk("rst_f_ch",    f_out_ch, 0);
    chk("rst_r_valid", r_out_valid, 0);
    chk("rst_r_data",  r_out_data, 0);
    chk("rst_r_ch",    r_out_ch, 0);
    chk("rst_f_ready", f_in_ready, 4'b0001);
    chk("rst_r_ready", r_in_ready, 4'b0001);
    rst_n = 1'b1;
    step();
    chk("rel_f_valid", f_out_valid, 1);
    chk("rel_f_ch",    f_out_ch, 0);
    chk("rel_f_data",  f_out_data, 32'hD0);
    chk("rel_r_valid", r_out_valid, 1);
    chk("rel_r_ch",    r_out_ch, 0);
    chk("rel_r_data",  r_out_data, 32'hD0);

    // Fixed priority: channel 1 beats channel 3 until it stops requesting
    do_reset();
    in_valid = 4'b1010;
    set_ch(1, 32'h11, 1'b1);
    set_ch(3, 32'h33, 1'b1);
    #1;
    chk("fp_ready", f_in_ready, 4'b0010);
    step();
    chk("fp_data1", f_out_data, 32'h11);
    chk("fp_ch1",   f_out_ch, 1);
    step();
    chk("fp_data1b", f_out_data, 32'h11);
    chk("fp_ch1b",   f_out_ch, 1);
    in_valid = 4'b1000;
    step();
    chk("fp_data3", f_out_data, 32'h33);
    chk("fp_ch3",   f_out_ch, 3);
    chk("fp_valid", f_out_valid, 1);

    // Round-robin with all channels continuously valid, single-beat packets
    do_reset();
    in_valid = 4'hF;
    for (int k = 0; k < NCH; k++) set_ch(k, 32'hC0 + k, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rr_ch%0d", i),    r_out_ch, i % 4);
      chk($sformatf("rr_data%0d", i),  r_out_data, 32'hC0 + (i % 4));
      chk($sformatf("rr_valid%0d", i), r_out_valid, 1);
    end

    // Packet lock: channel 2 three-beat packet, channel 0 waits
    do_reset();
    in_valid = 4'b0100;
    set_ch(2, 32'h21, 1'b0);
    set_ch(0, 32'hA0, 1'b1);
    step();
    chk("pk_f_ch_b1",   f_out_ch, 2);
    chk("pk_f_data_b1", f_out_data, 32'h21);
    chk("pk_r_ch_b1",   r_out_ch, 2);
    in_valid = 4'b0101;
    set_ch(2, 32'h22, 1'b0);
    #1;
    chk("pk_f_ready_b2", f_in_ready, 4'b0100);
    chk("pk_r_ready_b2", r_in_ready, 4'b0100);
    step();
    chk("pk_f_ch_b2",   f_out_ch, 2);
    chk("pk_f_data_b2", f_out_data, 32'h22);
    set_ch(2, 32'h23, 1'b1);
    #1;
    chk("pk_f_ready_b3", f_in_ready, 4'b0100);
    chk("pk_r_ready_b3", r_in_ready, 4'b0100);
    step();
    chk("pk_f_ch_b3",   f_out_ch, 2);
    chk("pk_f_data_b3", f_out_data, 32'h23);
    chk("pk_f_last_b3", f_out_last, 1);
    chk("pk_r_data_b3", r_out_data, 32'h23);
    in_valid = 4'b0001;
    #1;
    chk("pk_f_ready_c0", f_in_ready, 4'b0001);
    step();
    chk("pk_f_ch_c0",   f_out_ch, 0);
    chk("pk_f_data_c0", f_out_data, 32'hA0);
    chk("pk_r_ch_c0",   r_out_ch, 0);

    // Backpressure: held beat stays put, nothing accepted, then same-edge reload
    do_reset();
    in_valid = 4'b0001;
    set_ch(0, 32'hA5, 1'b1);
    step();
    chk("bp_load", f_out_data, 32'hA5);
    out_ready = 1'b0;
    set_ch(0, 32'h5A, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_f_ready%0d", i), f_in_ready, 4'b0000);
      chk($sformatf("bp_r_ready%0d", i), r_in_ready, 4'b0000);
      step();
      chk($sformatf("bp_f_data%0d", i),  f_out_data, 32'hA5);
      chk($sformatf("bp_f_valid%0d", i), f_out_valid, 1);
      chk($sformatf("bp_r_data%0d", i),  r_out_data, 32'hA5);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_rel", f_in_ready, 4'b0001);
    step();
    chk("bp_f_next",  f_out_data, 32'h5A);
    chk("bp_f_vnext", f_out_valid, 1);
    chk("bp_r_next",  r_out_data, 32'h5A);

    // Reset mid-packet on channel 1 drops the lock and the held beat
    do_reset();
    in_valid = 4'b0010;
    set_ch(1, 32'h41, 1'b0);
    step();
    set_ch(1, 32'h42, 1'b0);
    step();
    chk("mr_pre_data", f_out_data, 32'h42);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_f_valid", f_out_valid, 0);
    chk("mr_f_data",  f_out_data, 0);
    chk("mr_f_ch",    f_out_ch, 0);
    chk("mr_r_valid", r_out_valid, 0);
    chk("mr_r_data",  r_out_data, 0);
    in_valid = 4'b0011;
    set_ch(0, 32'h0B, 1'b1);
    set_ch(1, 32'h43, 1'b0);
    #1;
    chk("mr_f_ready", f_in_ready, 4'b0001);
    chk("mr_r_ready", r_in_ready, 4'b0001);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_f_ch0",   f_out_ch, 0);
    chk("mr_f_data0", f_out_data, 32'h0B);
    chk("mr_r_ch0",   r_out_ch, 0);
    chk("mr_r_data0", r_out_data, 32'h0B);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
